line_buffer_responder: RTL and testbench
========================================

LINE_BUFFER_RESPONDER -- requirements
Module: line_buffer_responder

Interface
REQ-001 Parameters SHALL be none; line size is fixed at 256 bits (32 bytes, 8 words), address offset bits [4:0], tag bits [31:5].
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 read  input  1  CPU read request, held until resp.
REQ-005 write  input  1  CPU write request, held until resp.
REQ-006 wmask  input  4  byte enables for write; bit i enables wdata[8i+7:8i].
REQ-007 address  input  32  CPU byte address; bits [1:0] ignored.
REQ-008 wdata  input  32  CPU write data.
REQ-009 resp  output  1  single-cycle completion pulse.
REQ-010 rdata  output  32  read data, valid while resp=1.
REQ-011 pmem_read  output  1  line fill request, held until pmem_resp.
REQ-012 pmem_write  output  1  line writeback request, held until pmem_resp.
REQ-013 pmem_address  output  32  line-aligned address, bits [4:0]=0.
REQ-014 pmem_wdata  output  256  line being written back.
REQ-015 pmem_resp  input  1  lower-memory completion pulse.
REQ-016 pmem_rdata  input  256  fill data, valid with pmem_resp.

Function
REQ-017 Block SHALL hold one line: line[255:0], tag[26:0], valid, dirty.
REQ-018 FSM SHALL have states IDLE, WB, FILL, RESPOND.
REQ-019 Hit = valid && tag==address[31:5]; evaluated only in IDLE.
REQ-020 IDLE, (read|write), hit -> RESPOND.
REQ-021 IDLE, (read|write), miss, !(valid&&dirty) -> FILL.
REQ-022 IDLE, (read|write), miss, valid&&dirty -> WB.
REQ-023 WB: pmem_write=1, pmem_address={tag,5'b0}, pmem_wdata=line; on pmem_resp -> FILL and dirty cleared.
REQ-024 FILL: pmem_read=1, pmem_address={address[31:5],5'b0}; on pmem_resp line<=pmem_rdata, tag<=address[31:5], valid<=1, dirty<=0, -> RESPOND.
REQ-025 RESPOND: resp=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-026 rdata SHALL equal line word address[4:2] (word 0 = line[31:0]) whenever state=RESPOND; 0 otherwise.
REQ-027 Write in RESPOND: at the closing edge, bytes of word address[4:2] with wmask bit set replaced by wdata; dirty<=1 even if wmask=0.
REQ-028 read and write both high SHALL be treated as write; rdata still driven per REQ-026.
REQ-029 Latency: hit resp in cycle N+1 after request sampled in cycle N; clean miss resp one cycle after fill pmem_resp; dirty miss adds the writeback.
REQ-030 pmem_read and pmem_write SHALL never be high together; both 0 outside WB/FILL; pmem_address=0 and pmem_wdata=0 outside WB/FILL.
REQ-031 Request dropped mid-miss (protocol violation): FSM SHALL complete the sequence and still pulse resp once.
REQ-032 Request present in cycle after RESPOND SHALL be treated as a new request.
REQ-033 pmem_resp outside WB/FILL SHALL be ignored.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, valid=0, dirty=0, tag=0, line=0, resp=0, rdata=0, pmem_read=0, pmem_write=0, including mid-WB/FILL.
REQ-035 After rst_n rises the first request SHALL miss.

Verification
REQ-036 Cold read 0x0000_1004; pmem_rdata word1=0xDEADBEEF, pmem_resp after 3 cycles -> pmem_read at 0x0000_1000, resp one cycle after pmem_resp, rdata=0xDEADBEEF.
REQ-037 Then write 0x0000_1008 wdata=0x11223344 wmask=0b0011, then read 0x0000_1008 -> each resp one cycle after request, no pmem activity, rdata low half=0x3344, upper half = prior fill data.
REQ-038 Then read 0x0000_2000 -> pmem_write at 0x0000_1000 carrying merged line, then pmem_read at 0x0000_2000, single resp, dirty=0 after.
REQ-039 Assert rst_n=0 during FILL -> pmem_read drops same cycle, next read to same line misses again.
REQ-040 read and write both high on hit, wmask=0xF -> write applied, dirty=1, one resp; pmem_resp injected in IDLE -> no state change.

Source files
------------

// File: rtl/line_buffer_responder.sv
// Single-line write-back buffer between a CPU port and a 256-bit lower memory.
// The buffer holds one line. A miss on a dirty line writes it back before the fill.
module line_buffer_responder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         read,
  input  logic         write,
  input  logic [3:0]   wmask,
  input  logic [31:0]  address,
  input  logic [31:0]  wdata,
  output logic         resp,
  output logic [31:0]  rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESPOND} state_t;

  state_t         state, state_nxt;
  logic [255:0]   line;
  logic [26:0]    tag;
  logic           valid;
  logic           dirty;
  logic           hit;
  logic [2:0]     word_sel;
  logic [31:0]    cur_word;
  logic           addr_lo_unused;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  assign word_sel       = address[4:2];
  assign cur_word       = line[{word_sel, 5'b00000} +: 32];
  assign hit            = valid && (tag == address[31:5]);
  assign addr_lo_unused = ^address[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    resp         = 1'b0;
    rdata        = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (read || write) begin
          if (hit)                state_nxt = RESPOND;
          else if (valid && dirty) state_nxt = WB;
          else                    state_nxt = FILL;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag, 5'b00000};
        pmem_wdata   = line;
        if (pmem_resp) state_nxt = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {address[31:5], 5'b00000};
        if (pmem_resp) state_nxt = RESPOND;
      end
      RESPOND: begin
        resp      = 1'b1;
        rdata     = cur_word;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line storage: the write merge lands on the edge that closes RESPOND, so
  // rdata in that cycle still shows the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line  <= '0;
      tag   <= '0;
      valid <= 1'b0;
      dirty <= 1'b0;
    end else begin
      case (state)
        WB: begin
          if (pmem_resp) dirty <= 1'b0;
        end
        FILL: begin
          if (pmem_resp) begin
            line  <= pmem_rdata;
            tag   <= address[31:5];
            valid <= 1'b1;
            dirty <= 1'b0;
          end
        end
        RESPOND: begin
          if (write) begin
            line[{word_sel, 5'b00000} +: 32] <= merge_bytes(cur_word, wdata, wmask);
            dirty <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_responder.sv
// Bench for line_buffer_responder: directed vector table, reset/injection
// sequences, then random traffic checked against a flat-memory reference.
module tb_line_buffer_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [3:0]   wmask = '0;
  logic [31:0]  address = '0;
  logic [31:0]  wdata = '0;
  logic         resp;
  logic [31:0]  rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  line_buffer_responder dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .wmask(wmask),
    .address(address), .wdata(wdata), .resp(resp), .rdata(rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  // Lower memory (responder-owned) and its activity log
  logic [255:0] store [logic [26:0]];
  int           n_fill = 0;
  int           n_wb = 0;
  int           presp_cyc = 0;
  logic [31:0]  fill_addr = '0;
  logic [31:0]  wb_addr = '0;
  int           pm_delay = 3;
  bit           inject = 1'b0;

  // Reference: CPU-visible flat memory, plus which line should be resident
  logic [31:0]  ref_mem [logic [29:0]];
  logic [26:0]  m_line = '0;
  bit           m_valid = 1'b0;
  bit           m_written = 1'b0;

  function automatic logic [255:0] fetch_line(input logic [26:0] t);
    logic [255:0] l;
    if (store.exists(t)) return store[t];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = {t, w[2:0], 2'b00};
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return {a[31:2], 2'b00};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = ref_rd(a);
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[a[31:2]] = w;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Lower-memory responder
  initial begin : responder
    int cnt;
    logic [255:0] l;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    l = fetch_line(27'h80);
    l[63:32] = 32'hDEADBEEF;
    store[27'h80] = l;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (!rst_n) begin
        cnt = 0;
      end else if (inject && !pmem_read && !pmem_write) begin
        pmem_rdata = {8{$urandom}};
        pmem_resp = 1'b1;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= pm_delay) begin
          if (pmem_write) begin
            store[pmem_address[31:5]] = pmem_wdata;
            wb_addr = pmem_address;
            n_wb++;
          end else begin
            pmem_rdata = fetch_line(pmem_address[31:5]);
            fill_addr = pmem_address;
            n_fill++;
          end
          presp_cyc = cyc;
          pmem_resp = 1'b1;
        end
      end
    end
  end

  task automatic inv_check();
    chk("pmem_exclusive", 64'(pmem_read & pmem_write), 64'd0);
    if (!(pmem_read || pmem_write)) chk("pmem_idle_zero", 64'(|{pmem_address, pmem_wdata}), 64'd0);
    if (!resp) chk("rdata_idle_zero", 64'(rdata), 64'd0);
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m,
                            output logic [31:0] rdv, output int nf, output int nw,
                            output logic [31:0] wa, output logic [31:0] fa, output bit lat_ok);
    int f0, w0, lat;
    bit got;
    f0 = n_fill; w0 = n_wb; lat = 0; got = 1'b0; rdv = '0; lat_ok = 1'b0;
    @(posedge clk); #1;
    read = rd; write = wr; address = a; wdata = wd; wmask = m;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      inv_check();
      if (resp) begin
        got = 1'b1;
        rdv = rdata;
        lat_ok = (n_fill == f0) ? (lat == 2) : (cyc == presp_cyc + 1);
      end
    end
    chk("resp_seen", 64'(got), 64'd1);
    nf = n_fill - f0; nw = n_wb - w0; wa = wb_addr; fa = fill_addr;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("resp_single_pulse", 64'(resp), 64'd0);
  endtask

  task automatic expect_access(input string nm, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                               input logic [31:0] exp_rd, input logic exp_hit, input logic exp_wb);
    logic [31:0] rdv, wa, fa;
    int nf, nw;
    bit lat_ok, mh;
    logic [26:0] prev_line;
    prev_line = m_line;
    mh = m_valid && (m_line == a[31:5]);
    run_access(rd, wr, a, wd, m, rdv, nf, nw, wa, fa, lat_ok);
    chk({nm, "_rdata"}, 64'(rdv), 64'(exp_rd));
    chk({nm, "_fills"}, 64'(nf), exp_hit ? 64'd0 : 64'd1);
    chk({nm, "_writebacks"}, 64'(nw), exp_wb ? 64'd1 : 64'd0);
    chk({nm, "_latency"}, 64'(lat_ok), 64'd1);
    if (!exp_hit) chk({nm, "_fill_addr"}, 64'(fa), 64'({a[31:5], 5'b00000}));
    if (exp_wb)   chk({nm, "_wb_addr"}, 64'(wa), 64'({prev_line, 5'b00000}));
    if (wr) ref_write(a, wd, m);
    m_written = (mh ? m_written : 1'b0) | wr;
    m_line = a[31:5];
    m_valid = 1'b1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic        exp_wb;
  } vec_t;

  vec_t vecs [9];

  initial begin : main
    logic [31:0] bases [4];
    bit seen;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_1008, 32'h1122_3344, 4'h3, 32'h0000_1008, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0,         4'h0, 32'h0000_3344, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'h0, 32'h0000_2000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'h0, 32'h0000_3000, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_3004, 32'hCAFE_F00D, 4'hF, 32'h0000_3004, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0,         4'h0, 32'h0000_3344, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_1005, 32'h0,         4'h0, 32'hDEADBEEF, 1'b1, 1'b0};
    ref_mem[30'h0000_0401] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp", 64'(resp), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_pmem_read", 64'(pmem_read), 64'd0);
    chk("reset_pmem_write", 64'(pmem_write), 64'd0);
    chk("reset_pmem_address", 64'(pmem_address), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin
        // Stray pmem_resp while idle must be ignored
        @(posedge clk); #2 inject = 1'b1;
        @(posedge clk); #2 inject = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("inject_no_resp", 64'(resp), 64'd0);
          chk("inject_no_pmem", 64'({pmem_read, pmem_write}), 64'd0);
        end
      end
      expect_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wd, vecs[i].m, vecs[i].exp_rd, vecs[i].exp_hit, vecs[i].exp_wb);
    end

    // Reset asserted in the middle of a fill
    pm_delay = 50;
    @(posedge clk); #1;
    read = 1'b1; address = 32'h0000_5000;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    chk("midfill_started", 64'(seen), 64'd1);
    chk("midfill_addr", 64'(pmem_address), 64'h5000);
    #3 rst_n = 1'b0;
    #1;
    chk("midfill_pmem_read_drop", 64'(pmem_read), 64'd0);
    chk("midfill_resp", 64'(resp), 64'd0);
    chk("midfill_addr_zero", 64'(pmem_address), 64'd0);
    read = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    pm_delay = 3;
    m_valid = 1'b0;
    m_written = 1'b0;
    expect_access("post_reset_read", 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0,
                  ref_rd(32'h0000_5000), 1'b0, 1'b0);

    // Random traffic over a few lines so hits, clean and dirty misses all occur
    bases[0] = 32'h0000_4000; bases[1] = 32'h0000_4020;
    bases[2] = 32'hFFFF_FFE0; bases[3] = 32'h0000_0000;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, wd;
      logic [3:0] m;
      logic rd, wr;
      int r;
      bit mh;
      r  = $urandom_range(0, 3);
      rd = (r != 1);
      wr = (r == 1) || (r == 2);
      a  = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 31));
      wd = $urandom;
      m  = 4'($urandom_range(0, 15));
      pm_delay = $urandom_range(1, 4);
      mh = m_valid && (m_line == a[31:5]);
      expect_access($sformatf("rnd%0d", n), rd, wr, a, wd, m, ref_rd(a), mh,
                    !mh && m_valid && m_written);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
